fetch_target_queue: RTL and testbench

- Decoupling queue directly downstream of the next-line predictor.
- Each cycle it accepts one prediction (fetch-group PC, predicted next PC, taken, cut_pos) and presents entries in order to the I-cache fetch stage.
- It records backend resolution per entry.
- On in-order commit it emits a registered training update back to the predictor.

---
 rtl/fetch_target_queue_pkg.sv | 21 ++
 rtl/fetch_target_queue_storage.sv | 44 ++++
 rtl/fetch_target_queue.sv | 132 +++++++++++++
 tb/tb_fetch_target_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_target_queue_pkg.sv
// fetch_target_queue_pkg: shared FTQ depth, branch-type encodings and entry layout
package fetch_target_queue_pkg;
  localparam int FTQ_DEPTH = 8;
  typedef enum logic [1:0] {
    BR_DIRECT   = 2'd0,
    BR_INDIRECT = 2'd1,
    BR_RETURN   = 2'd2,
    BR_CALL     = 2'd3
  } br_type_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        taken;
    logic [1:0]  cut_pos;
    logic        resolved;
    logic        res_taken;
    logic [31:0] res_target;
    logic [1:0]  res_cut_pos;
    logic [1:0]  res_branch_type;
  } ftq_entry_t;
endpackage

// File: rtl/fetch_target_queue_storage.sv
// ftq_storage: FTQ entry array with prediction and resolve write ports, fetch and head read ports
//   i_wr_*  : prediction write (clears resolution)   i_res_* : resolution write
//   i_clr   : drop all resolved bits                  i_fetch_idx/i_head_idx : combinational reads
module ftq_storage
  import fetch_target_queue_pkg::*;
#(
  parameter int DEPTH = FTQ_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  ftq_entry_t       i_wr_entry,
  input  logic             i_res_en,
  input  logic [IDX_W-1:0] i_res_idx,
  input  logic             i_res_taken,
  input  logic [31:0]      i_res_target,
  input  logic [1:0]       i_res_cut_pos,
  input  logic [1:0]       i_res_branch_type,
  input  logic [IDX_W-1:0] i_fetch_idx,
  output ftq_entry_t       o_fetch_entry,
  input  logic [IDX_W-1:0] i_head_idx,
  output ftq_entry_t       o_head_entry
);
  ftq_entry_t r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k].resolved <= 1'b0;
    end else begin
      if (i_wr_en) r_mem[i_wr_idx] <= i_wr_entry;
      if (i_res_en) begin
        r_mem[i_res_idx].resolved        <= 1'b1;
        r_mem[i_res_idx].res_taken       <= i_res_taken;
        r_mem[i_res_idx].res_target      <= i_res_target;
        r_mem[i_res_idx].res_cut_pos     <= i_res_cut_pos;
        r_mem[i_res_idx].res_branch_type <= i_res_branch_type;
      end
    end
  end
  assign o_fetch_entry = r_mem[i_fetch_idx];
  assign o_head_entry  = r_mem[i_head_idx];
endmodule

// File: rtl/fetch_target_queue.sv
// fetch_target_queue: decoupling queue between next-line predictor and I-cache fetch with commit-time training
//   enq_*  : predictions in     fetch_* : in-order entries to fetch
//   res_*  : backend resolution cmt_*   : in-order commit     upd_* : registered training update
module fetch_target_queue
  import fetch_target_queue_pkg::*;
#(
  parameter int DEPTH = FTQ_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_next_pc,
  input  logic             enq_taken,
  input  logic [1:0]       enq_cut_pos,
  output logic [IDX_W-1:0] enq_idx,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [31:0]      fetch_pc,
  output logic [1:0]       fetch_cut_pos,
  output logic             fetch_taken,
  output logic [IDX_W-1:0] fetch_idx,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic [1:0]       res_cut_pos,
  input  logic [1:0]       res_branch_type,
  input  logic             cmt_valid,
  output logic             cmt_ready,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic             upd_taken,
  output logic [1:0]       upd_cut_pos,
  output logic [1:0]       upd_branch_type,
  output logic             upd_mispredict,
  output logic [IDX_W:0]   count
);
  localparam logic [IDX_W:0] L_FULL = (IDX_W+1)'(DEPTH);
  logic [IDX_W:0] r_head, r_fetch, r_tail, w_fetched;
  logic [IDX_W-1:0] w_res_off;
  logic w_enq, w_fetch, w_res, w_fwd, w_cmt, w_upd, w_rt, w_mis;
  logic [31:0] w_rtgt;
  logic [1:0] w_rcut, w_rtype;
  ftq_entry_t w_wr_entry, w_fetch_entry, w_head_entry;
  logic r_upd_valid, r_upd_taken, r_upd_mis;
  logic [31:0] r_upd_pc, r_upd_target;
  logic [1:0] r_upd_cut, r_upd_type;
  assign count       = r_tail - r_head;
  assign w_fetched   = r_fetch - r_head;
  assign enq_ready   = count != L_FULL;
  assign enq_idx     = r_tail[IDX_W-1:0];
  assign fetch_valid = r_fetch != r_tail;
  assign cmt_ready   = r_head != r_fetch;
  assign w_enq   = enq_valid && enq_ready && !flush;
  assign w_fetch = fetch_valid && fetch_ready && !flush;
  assign w_cmt   = cmt_valid && cmt_ready && !flush;
  // distance from head in ring order; accepted only inside the fetched-but-uncommitted window
  assign w_res_off = res_idx - r_head[IDX_W-1:0];
  assign w_res     = res_valid && !flush && ({1'b0, w_res_off} < w_fetched);
  // a resolve landing on the head in the commit cycle is forwarded straight into the update
  assign w_fwd   = w_res && (w_res_off == '0);
  assign w_rt    = w_fwd ? res_taken : w_head_entry.res_taken;
  assign w_rtgt  = w_fwd ? res_target : w_head_entry.res_target;
  assign w_rcut  = w_fwd ? res_cut_pos : w_head_entry.res_cut_pos;
  assign w_rtype = w_fwd ? res_branch_type : w_head_entry.res_branch_type;
  assign w_upd   = w_cmt && (w_head_entry.resolved || w_fwd);
  assign w_mis   = (w_rt != w_head_entry.taken) ||
                   (w_rt && ((w_rtgt != w_head_entry.next_pc) || (w_rcut != w_head_entry.cut_pos)));
  always_comb begin
    w_wr_entry         = '0;
    w_wr_entry.pc      = enq_pc;
    w_wr_entry.next_pc = enq_next_pc;
    w_wr_entry.taken   = enq_taken;
    w_wr_entry.cut_pos = enq_cut_pos;
  end
  ftq_storage #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_storage (
    .clk(clk), .rst(rst), .i_clr(flush),
    .i_wr_en(w_enq), .i_wr_idx(r_tail[IDX_W-1:0]), .i_wr_entry(w_wr_entry),
    .i_res_en(w_res), .i_res_idx(res_idx), .i_res_taken(res_taken), .i_res_target(res_target),
    .i_res_cut_pos(res_cut_pos), .i_res_branch_type(res_branch_type),
    .i_fetch_idx(r_fetch[IDX_W-1:0]), .o_fetch_entry(w_fetch_entry),
    .i_head_idx(r_head[IDX_W-1:0]), .o_head_entry(w_head_entry)
  );
  assign fetch_pc      = w_fetch_entry.pc;
  assign fetch_cut_pos = w_fetch_entry.cut_pos;
  assign fetch_taken   = w_fetch_entry.taken;
  assign fetch_idx     = r_fetch[IDX_W-1:0];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_fetch <= '0;
      r_tail  <= '0;
    end else begin
      r_head  <= r_head + (IDX_W+1)'(w_cmt);
      r_fetch <= r_fetch + (IDX_W+1)'(w_fetch);
      r_tail  <= r_tail + (IDX_W+1)'(w_enq);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_valid  <= 1'b0;
      r_upd_pc     <= '0;
      r_upd_target <= '0;
      r_upd_taken  <= 1'b0;
      r_upd_cut    <= '0;
      r_upd_type   <= '0;
      r_upd_mis    <= 1'b0;
    end else begin
      r_upd_valid <= w_upd;
      if (w_upd) begin
        r_upd_pc     <= w_head_entry.pc;
        r_upd_target <= w_rtgt;
        r_upd_taken  <= w_rt;
        r_upd_cut    <= w_rcut;
        r_upd_type   <= w_rtype;
        r_upd_mis    <= w_mis;
      end
    end
  end
  assign upd_valid       = r_upd_valid;
  assign upd_pc          = r_upd_pc;
  assign upd_target      = r_upd_target;
  assign upd_taken       = r_upd_taken;
  assign upd_cut_pos     = r_upd_cut;
  assign upd_branch_type = r_upd_type;
  assign upd_mispredict  = r_upd_mis;
endmodule

// File: tb/tb_fetch_target_queue.sv
// tb_fetch_target_queue: directed self-checking bench for fetch_target_queue
module tb_fetch_target_queue;
  import fetch_target_queue_pkg::*;
  localparam int IDX_W = 3;
  logic clk = 1'b0, rst, flush;
  logic enq_valid, enq_ready, enq_taken;
  logic [31:0] enq_pc, enq_next_pc;
  logic [1:0] enq_cut_pos;
  logic [IDX_W-1:0] enq_idx, fetch_idx, res_idx;
  logic fetch_valid, fetch_ready, fetch_taken;
  logic [31:0] fetch_pc;
  logic [1:0] fetch_cut_pos;
  logic res_valid, res_taken;
  logic [31:0] res_target;
  logic [1:0] res_cut_pos, res_branch_type;
  logic cmt_valid, cmt_ready;
  logic upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [1:0] upd_cut_pos, upd_branch_type;
  logic [IDX_W:0] count;
  int checks = 0, errors = 0;

  fetch_target_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_next_pc(enq_next_pc),
    .enq_taken(enq_taken), .enq_cut_pos(enq_cut_pos), .enq_idx(enq_idx),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_cut_pos(fetch_cut_pos), .fetch_taken(fetch_taken), .fetch_idx(fetch_idx),
    .res_valid(res_valid), .res_idx(res_idx), .res_taken(res_taken), .res_target(res_target),
    .res_cut_pos(res_cut_pos), .res_branch_type(res_branch_type),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_cut_pos(upd_cut_pos), .upd_branch_type(upd_branch_type), .upd_mispredict(upd_mispredict),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; enq_valid = 0; enq_pc = 0; enq_next_pc = 0; enq_taken = 0; enq_cut_pos = 0;
    fetch_ready = 0; res_valid = 0; res_idx = 0; res_taken = 0; res_target = 0;
    res_cut_pos = 0; res_branch_type = 0; cmt_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] nxt, input logic t, input logic [1:0] cp);
    enq_valid = 1; enq_pc = pc; enq_next_pc = nxt; enq_taken = t; enq_cut_pos = cp;
    tick();
    enq_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid); end
    checks++; if (cmt_ready !== 1'b0) begin errors++; $display("FAIL reset_cmt_ready: got %b expected 0", cmt_ready); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %b expected 0", upd_valid); end
    enq(32'h0000_7000, 32'h0000_7010, 0, 0);
    enq(32'h0000_7100, 32'h0000_7110, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", count); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL midreset_fetch_valid: got %b expected 0", fetch_valid); end
  endtask

  task automatic test_enq_fetch();
    do_reset();
    enq_valid = 1; enq_pc = 32'h1000; enq_next_pc = 32'h1010; enq_taken = 0; enq_cut_pos = 0;
    #1;
    checks++; if (enq_idx !== 3'd0) begin errors++; $display("FAIL enq_idx: got %0d expected 0", enq_idx); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL same_cycle_fetch_valid: got %b expected 0", fetch_valid); end
    tick();
    enq_valid = 0;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b expected 1", fetch_valid); end
    checks++; if (fetch_pc !== 32'h1000) begin errors++; $display("FAIL fetch_pc: got %h expected 00001000", fetch_pc); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL count_one: got %0d expected 1", count); end
    checks++; if (cmt_ready !== 1'b0) begin errors++; $display("FAIL cmt_ready_unfetched: got %b expected 0", cmt_ready); end
    fetch_ready = 1;
    tick();
    fetch_ready = 0;
    checks++; if (cmt_ready !== 1'b1) begin errors++; $display("FAIL cmt_ready_fetched: got %b expected 1", cmt_ready); end
    cmt_valid = 1;
    tick();
    cmt_valid = 0;
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL unresolved_upd: got %b expected 0", upd_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drained_count: got %0d expected 0", count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) enq(32'h3000 + 32'(16 * i), 32'h3000 + 32'(16 * i + 16), 0, 0);
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready: got %b expected 0", enq_ready); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", count); end
    enq(32'hdead_0000, 32'hdead_0010, 1, 3);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ninth_dropped_count: got %0d expected 8", count); end
    fetch_ready = 1;
    tick();
    fetch_ready = 0;
    checks++; if (fetch_pc !== 32'h3010) begin errors++; $display("FAIL full_fetch_pc: got %h expected 00003010", fetch_pc); end
    cmt_valid = 1; enq_valid = 1; enq_pc = 32'hbeef_0000;
    tick();
    cmt_valid = 0; enq_valid = 0;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_cmt_enq_count: got %0d expected 7", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL after_cmt_enq_ready: got %b expected 1", enq_ready); end
    checks++; if (enq_idx !== 3'd0) begin errors++; $display("FAIL after_cmt_enq_idx: got %0d expected 0", enq_idx); end
  endtask

  task automatic test_mispredict();
    do_reset();
    enq(32'h5000, 32'h2000, 1, 1);
    fetch_ready = 1;
    tick();
    fetch_ready = 0;
    res_valid = 1; res_idx = 0; res_taken = 1; res_target = 32'h2400; res_cut_pos = 1; res_branch_type = BR_CALL;
    tick();
    res_valid = 0;
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL resolve_no_upd: got %b expected 0", upd_valid); end
    cmt_valid = 1;
    tick();
    cmt_valid = 0;
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL mis_upd_valid: got %b expected 1", upd_valid); end
    checks++; if (upd_pc !== 32'h5000) begin errors++; $display("FAIL mis_upd_pc: got %h expected 00005000", upd_pc); end
    checks++; if (upd_target !== 32'h2400) begin errors++; $display("FAIL mis_upd_target: got %h expected 00002400", upd_target); end
    checks++; if (upd_branch_type !== 2'd3) begin errors++; $display("FAIL mis_upd_type: got %0d expected 3", upd_branch_type); end
    checks++; if (upd_taken !== 1'b1) begin errors++; $display("FAIL mis_upd_taken: got %b expected 1", upd_taken); end
    checks++; if (upd_mispredict !== 1'b1) begin errors++; $display("FAIL mis_upd_mispredict: got %b expected 1", upd_mispredict); end
    tick();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL upd_one_cycle: got %b expected 0", upd_valid); end
  endtask

  task automatic test_forward();
    do_reset();
    enq(32'h6000, 32'h6010, 0, 0);
    fetch_ready = 1;
    tick();
    fetch_ready = 0;
    res_valid = 1; res_idx = 0; res_taken = 0; res_target = 32'h6010; res_cut_pos = 0; res_branch_type = BR_DIRECT;
    cmt_valid = 1;
    tick();
    res_valid = 0; cmt_valid = 0;
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL fwd_upd_valid: got %b expected 1", upd_valid); end
    checks++; if (upd_mispredict !== 1'b0) begin errors++; $display("FAIL fwd_mispredict: got %b expected 0", upd_mispredict); end
    checks++; if (upd_pc !== 32'h6000) begin errors++; $display("FAIL fwd_upd_pc: got %h expected 00006000", upd_pc); end
    enq(32'h6100, 32'h6110, 0, 0);
    res_valid = 1; res_idx = 1; res_taken = 1; res_target = 32'h9999;
    tick();
    res_valid = 0;
    fetch_ready = 1;
    tick();
    fetch_ready = 0;
    cmt_valid = 1;
    tick();
    cmt_valid = 0;
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL unfetched_resolve_ignored: got %b expected 0", upd_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) enq(32'h4000 + 32'(4 * i), 32'h4000 + 32'(4 * i + 4), 0, 0);
    fetch_ready = 1;
    repeat (3) tick();
    fetch_ready = 0;
    res_valid = 1; res_idx = 1; res_taken = 1; res_target = 32'h1234;
    tick();
    res_valid = 0;
    flush = 1; enq_valid = 1; enq_pc = 32'hffff_0000; cmt_valid = 1;
    tick();
    flush = 0; enq_valid = 0; cmt_valid = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL flush_fetch_valid: got %b expected 0", fetch_valid); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL flush_upd_valid: got %b expected 0", upd_valid); end
    checks++; if (cmt_ready !== 1'b0) begin errors++; $display("FAIL flush_cmt_ready: got %b expected 0", cmt_ready); end
    res_valid = 1; res_idx = 1; res_taken = 1; res_target = 32'h5678;
    tick();
    res_valid = 0;
    enq(32'h9000, 32'h9004, 0, 0);
    enq(32'h9004, 32'h9008, 0, 0);
    checks++; if (fetch_pc !== 32'h9000) begin errors++; $display("FAIL post_flush_fetch_pc: got %h expected 00009000", fetch_pc); end
    fetch_ready = 1;
    repeat (2) tick();
    fetch_ready = 0;
    cmt_valid = 1;
    tick();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL post_flush_upd0: got %b expected 0", upd_valid); end
    tick();
    cmt_valid = 0;
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL post_flush_upd1: got %b expected 0", upd_valid); end
  endtask

  task automatic test_back_to_back();
    int fetch_n = 0, cmt_n = 0;
    logic will_cmt;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      enq_valid = (c < 20); enq_pc = 32'h8000 + 32'(4 * c); enq_next_pc = enq_pc + 4;
      fetch_ready = 1; cmt_valid = 1;
      res_valid = 1; res_idx = 3'(cmt_n); res_taken = 0; res_target = 0; res_cut_pos = 0; res_branch_type = BR_DIRECT;
      #1;
      if (fetch_valid) begin
        checks++; if (fetch_pc !== 32'h8000 + 32'(4 * fetch_n)) begin errors++; $display("FAIL wrap_fetch_pc[%0d]: got %h expected %h", fetch_n, fetch_pc, 32'h8000 + 32'(4 * fetch_n)); end
        fetch_n++;
      end
      will_cmt = cmt_ready;
      tick();
      if (will_cmt) begin
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h8000 + 32'(4 * cmt_n)) begin errors++; $display("FAIL wrap_upd[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", cmt_n, upd_valid, upd_pc, 32'h8000 + 32'(4 * cmt_n)); end
        cmt_n++;
      end
    end
    idle();
    checks++; if (fetch_n != 20) begin errors++; $display("FAIL wrap_fetch_total: got %0d expected 20", fetch_n); end
    checks++; if (cmt_n != 20) begin errors++; $display("FAIL wrap_cmt_total: got %0d expected 20", cmt_n); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_final_count: got %0d expected 0", count); end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_enq_fetch();
    test_full();
    test_mispredict();
    test_forward();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
